// File: rtl/mem_lane_ctrl_pkg.sv
// Shared encodings for the byte-lane memory access controller and its RAM.
package mem_lane_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_RESP    = 2'b10
  } state_e;

  // Number of byte-address bits that select a lane within one RAM word.
  function automatic int lane_bits_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_bram_be.sv
// Single-port block RAM with per-byte write enables and a registered,
// read-first output (one cycle of read latency).
module mem_bram_be #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_W-1:0]    addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_array [2**DEPTH_W];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    rdata_reg <= mem_array[addr];
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we && be[i]) begin
        mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_lane_ctrl.sv
// Load/store controller: byte-lane selection, sign/zero extension and
// misalignment rejection in front of a byte-enabled block RAM.
module mem_lane_ctrl
  import mem_lane_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              Clk_m,
  input  logic              Rst_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [1:0]        Req_Size,
  input  logic              Req_Signed,
  input  logic [DATA_W-1:0] Req_WData,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_RData,
  output logic              Rsp_Err,
  output logic [7:0]        Err_Cnt
);

  localparam int LANE_BITS = lane_bits_f(DATA_W);
  localparam int LANES     = DATA_W / 8;
  localparam int DEPTH_W   = ADDR_W - LANE_BITS;

  state_e                 state_reg, state_next;
  size_e                  size_reg;
  logic [LANE_BITS-1:0]   lane_reg;
  logic                   signed_reg;
  logic [DATA_W-1:0]      rdata_reg;
  logic                   err_reg;
  logic [7:0]             err_cnt_reg;

  size_e                  req_size;
  logic [LANE_BITS-1:0]   req_lane;
  logic                   accept;
  logic                   reject;
  logic                   ram_we;
  logic [LANES-1:0]       ram_be;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;
  logic [DATA_W-1:0]      load_data;

  assign req_size  = size_e'(Req_Size);
  assign req_lane  = Req_Addr[LANE_BITS-1:0];
  assign Req_Ready = Rst_n && (state_reg == ST_IDLE);
  assign accept    = Req_Valid && Req_Ready;
  assign ram_we    = accept && Req_Write && !reject;

  always_comb begin
    reject = 1'b0;
    case (req_size)
      SZ_HALF: reject = req_lane[0];
      SZ_WORD: reject = |req_lane;
      SZ_RSVD: reject = 1'b1;
      default: reject = 1'b0;
    endcase
  end

  // Store data is right-aligned, so replicate it across the lanes it may land in.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANE_BITS-1:0] LANE_IDX = LANE_BITS'(gi);
      assign ram_be[gi] = (req_size == SZ_WORD) ||
                          ((req_size == SZ_HALF) && ((req_lane >> 1) == (LANE_IDX >> 1))) ||
                          ((req_size == SZ_BYTE) && (req_lane == LANE_IDX));
      assign ram_wdata[gi*8 +: 8] = (req_size == SZ_BYTE) ? Req_WData[7:0] :
                                    (req_size == SZ_HALF) ? Req_WData[(gi%2)*8 +: 8] :
                                                            Req_WData[gi*8 +: 8];
    end
  endgenerate

  mem_bram_be #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_bram (
    .clk   (Clk_m),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (Req_Addr[ADDR_W-1:LANE_BITS]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    load_data = ram_rdata;
    case (size_reg)
      SZ_BYTE: load_data = {{(DATA_W-8){signed_reg & ram_rdata[{lane_reg, 3'b000} + 7]}},
                            ram_rdata[{lane_reg, 3'b000} +: 8]};
      SZ_HALF: load_data = {{(DATA_W-16){signed_reg & ram_rdata[{lane_reg, 3'b000} + 15]}},
                            ram_rdata[{lane_reg, 3'b000} +: 16]};
      default: load_data = ram_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = (Req_Write || reject) ? ST_RESP : ST_RD_WAIT;
      ST_RD_WAIT: state_next = ST_RESP;
      ST_RESP:    if (Rsp_Ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_m) begin
    if (!Rst_n) begin
      state_reg   <= ST_IDLE;
      size_reg    <= SZ_BYTE;
      lane_reg    <= '0;
      signed_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg   <= req_size;
        lane_reg   <= req_lane;
        signed_reg <= Req_Signed;
        rdata_reg  <= '0;
        err_reg    <= reject;
        if (reject && (err_cnt_reg != 8'hFF)) begin
          err_cnt_reg <= err_cnt_reg + 8'd1;
        end
      end
      if (state_reg == ST_RD_WAIT) begin
        rdata_reg <= load_data;
      end
    end
  end

  assign Rsp_Valid = (state_reg == ST_RESP);
  assign Rsp_RData = rdata_reg;
  assign Rsp_Err   = err_reg;
  assign Err_Cnt   = err_cnt_reg;

endmodule

// File: doc/mem_lane_ctrl.md
# mem_lane_ctrl

Parametrised data-memory access controller: wraps a synchronous single-port RAM behind a request/response handshake and performs byte, halfword and word loads and stores on a byte-addressed space. It selects byte lanes, applies sign or zero extension, and rejects misaligned or reserved-size accesses. It sits between the datapath's memory stage and the block RAM, replacing direct RAM hookup with fixed lane muxing.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, at least 16
- ADDR_W, 8, byte-address width; RAM depth = 2^(ADDR_W − LANE_BITS) words, LANE_BITS = log2(DATA_W/8)
- Clk_m  in  1  single clock, all logic rising-edge
- Rst_n  in  1  reset, synchronous, active-low
- Req_Valid  in  1  request present
- Req_Ready  out  1  controller can accept
- Req_Write  in  1  1 = store, 0 = load
- Req_Addr  in  ADDR_W  byte address
- Req_Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Req_Signed  in  1  sign-extend loads (ignored for word and stores)
- Req_WData  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- Rsp_Valid  out  1  response present
- Rsp_Ready  in  1  consumer takes response
- Rsp_RData  out  DATA_W  load result, right-aligned and extended; 0 for stores/errors
- Rsp_Err  out  1  access rejected
- Err_Cnt  out  8  saturating count of rejected requests

## Operation
- Accept = Req_Valid & Req_Ready & Rst_n.
- States: IDLE (Req_Ready=1), RD_WAIT, RESP (Req_Ready=0 in both).
- IDLE → RD_WAIT on accepted valid load; IDLE → RESP on accepted store or rejected request; RD_WAIT → RESP unconditionally; RESP → IDLE when Rsp_Ready=1.
- Rejection: Req_Size=11; half with Req_Addr[0]≠0; word with Req_Addr[LANE_BITS−1:0]≠0. Rejected request: no RAM write, Rsp_Err=1, Rsp_RData=0, Err_Cnt+1 saturating at 255.
- Store: RAM write in the accept cycle with per-lane byte enables; lane = Req_Addr[LANE_BITS−1:0]. Byte data replicated into selected lane; half into lanes lane, lane+1; word writes all lanes. Unselected bytes unchanged.
- Load: RAM address driven in accept cycle; RAM output valid in RD_WAIT; selected byte/half extracted, extended per Req_Signed (word passes through), registered into Rsp_RData on RD_WAIT→RESP edge.
- Request fields latched at accept; input changes afterwards have no effect.
- Rsp_Valid, Rsp_RData, Rsp_Err stable throughout RESP until consumed.
- No pipelining: one outstanding request.

## Timing
- Reset (Rst_n=0 at an edge): state IDLE, Req_Ready=0 while Rst_n low, 1 from first cycle after release; Rsp_Valid=0, Rsp_RData=0, Rsp_Err=0, Err_Cnt=0. RAM contents not cleared.
- Store/error latency: accept at edge T → Rsp_Valid=1 in cycle T+1.
- Load latency: accept at edge T → Rsp_Valid=1 in cycle T+2.
- Rsp_Ready high in first RESP cycle → Req_Ready=1 next cycle; minimum 2 cycles per store, 3 per load.
- Rsp_Ready held low N cycles → response held N extra cycles, unchanged.
- Reset mid-operation (RD_WAIT or RESP): response dropped, outputs take reset values next cycle; a store already written stays written; no write while Rst_n=0 even if Req_Valid=1.
- Highest address (2^ADDR_W−1): byte access legal; no wrap into address 0.

## Structure
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), state encoding, LANE_BITS derivation function.
- Sub-module mem_bram_be: synchronous single-port RAM, DATA_W/8 byte write enables, registered read, one-cycle read latency, read-first.
- Top holds FSM, lane-select/extend logic, error counter.

## Test plan
- Word store 0x1111_2222 at 0x04, word load 0x04 → Rsp_RData=0x1111_2222, Rsp_Err=0, Rsp_Valid two cycles after accept.
- Byte store 0xAB at 0x05, then word load 0x04 → 0x1111_AB22; signed byte load 0x05 → 0xFFFF_FFAB; unsigned → 0x0000_00AB.
- Half store 0x8001 at 0x06, signed half load 0x06 → 0xFFFF_8001; unsigned → 0x0000_8001; word load 0x04 → 0x8001_AB22.
- Half store at 0x03, word load at 0x02, size 11 at 0x00 → each Rsp_Err=1, Rsp_RData=0, Err_Cnt=3, word at 0x00 unchanged; 260 rejects → Err_Cnt=255.
- Load with Rsp_Ready low 3 cycles → Rsp_Valid/Rsp_RData constant 3 cycles, Req_Ready=0, new Req_Valid ignored.
- Rst_n low during RD_WAIT → next cycle Rsp_Valid=0, Err_Cnt=0; prior store data still readable after release.
